cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath (ALU, branch-target and address generation). It replaces fixed-width combinational CLA chains: WIDTH is split into STAGES segments, each built from BLOCK-bit lookahead groups, with the carry registered between segments. It uses a valid/ready handshake with backpressure, and reports carry, signed-overflow and zero flags.

---
 rtl/cla_addsub_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
//
// Purpose:
//   WIDTH-bit A+B / A-B split into STAGES segments of SEG = WIDTH/STAGES bits.
//   Segment k is resolved in pipeline stage k from BLOCK-bit lookahead groups
//   that ripple into each other. The segment carry is registered and consumed
//   by segment k+1 one cycle later. The last stage register is the output
//   register; flags are derived from it, so they hold while stalled.
//
// Optional feature macro: CLA_SAT_EN
//   Defined   : i_sat=1 clamps a signed-overflowing result to the signed max/min.
//   Undefined : i_sat is ignored and results always wrap.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_valid   operands valid           o_ready  block accepts input this cycle
//   i_a, i_b  operands (WIDTH)         i_sub    0 = A+B, 1 = A-B
//   i_sat     saturate signed result (CLA_SAT_EN only)
//   o_valid   result valid             i_ready  downstream accepts result
//   o_sum     result (WIDTH)           o_cout   carry out of MSB (sub: 1 = no borrow)
//   o_ovf     signed overflow of the unsaturated result
//   o_zero    o_sum == 0
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sat,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / BLOCK;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1) begin : g_bad_stages
        $error("cla_addsub_pipe: STAGES must be >= 1");
    end
    if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_width
        $error("cla_addsub_pipe: WIDTH must be a multiple of STAGES*BLOCK");
    end

    // One segment: BLOCK-bit groups with full lookahead inside each group.
    // Every carry inside a group is a sum-of-products of g/p and the group
    // carry-in; the group carry-out then ripples into the next group.
    function automatic logic [SEG:0] cla_seg(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           cin
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG-1:0] s;
        logic           c_grp;
        logic           c_next;
        logic           c_bit;
        logic           prod;
        g      = a & b;
        p      = a ^ b;
        s      = '0;
        c_grp  = cin;
        c_next = 1'b0;
        for (int grp = 0; grp < NGRP; grp++) begin
            for (int i = 0; i <= BLOCK; i++) begin
                c_bit = 1'b0;
                prod  = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    c_bit = c_bit | (prod & g[grp*BLOCK + j]);
                    prod  = prod & p[grp*BLOCK + j];
                end
                c_bit = c_bit | (prod & c_grp);
                if (i < BLOCK) begin
                    s[grp*BLOCK + i] = p[grp*BLOCK + i] ^ c_bit;
                end else begin
                    c_next = c_bit;
                end
            end
            c_grp = c_next;
        end
        return {c_grp, s};
    endfunction

    // Per-stage state. Each stage carries the full operands (upper slices are
    // still to be processed; the MSBs are also needed for the overflow flag),
    // the partially completed sum and the carry into the next segment.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  be_q  [STAGES];
    logic [WIDTH-1:0]  be_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // Inputs to each stage: stage 0 takes the ports, stage k takes stage k-1.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_be  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [SEG:0]      seg_res;
    logic              adv;

`ifdef CLA_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;
    logic [STAGES-1:0] src_sat;
`else
    logic unused_sat;
    assign unused_sat = i_sat;
`endif

    // Whole pipeline moves together; it only stalls when the output
    // register is occupied and the consumer is not taking it.
    assign adv     = !v_q[LAST] || i_ready;
    assign o_ready = adv;

    always_comb begin
        v_d     = v_q;
        c_d     = c_q;
        seg_res = '0;
        src_v   = '0;
        src_c   = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]     = a_q[k];
            be_d[k]    = be_q[k];
            sum_d[k]   = sum_q[k];
            src_a[k]   = '0;
            src_be[k]  = '0;
            src_sum[k] = '0;
        end
`ifdef CLA_SAT_EN
        sat_d   = sat_q;
        src_sat = '0;
`endif

        // Subtraction as A + ~B + 1: the +1 enters as the segment-0 carry-in.
        src_v[0]   = i_valid;
        src_a[0]   = i_a;
        src_be[0]  = i_sub ? ~i_b : i_b;
        src_c[0]   = i_sub;
        src_sum[0] = '0;
`ifdef CLA_SAT_EN
        src_sat[0] = i_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_be[k]  = be_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sum[k] = sum_q[k-1];
`ifdef CLA_SAT_EN
            src_sat[k] = sat_q[k-1];
`endif
        end

        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                seg_res  = cla_seg(src_a[k][k*SEG +: SEG], src_be[k][k*SEG +: SEG], src_c[k]);
                v_d[k]   = src_v[k];
                a_d[k]   = src_a[k];
                be_d[k]  = src_be[k];
                c_d[k]   = seg_res[SEG];
                sum_d[k] = src_sum[k];
                sum_d[k][k*SEG +: SEG] = seg_res[SEG-1:0];
`ifdef CLA_SAT_EN
                sat_d[k] = src_sat[k];
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                be_q[k]  <= '0;
                sum_q[k] <= '0;
            end
`ifdef CLA_SAT_EN
            sat_q <= '0;
`endif
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                be_q[k]  <= be_d[k];
                sum_q[k] <= sum_d[k];
            end
`ifdef CLA_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    // Output decode from the last stage register only, so everything is
    // stable while the output is stalled.
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             ovf_raw;

    assign raw     = sum_q[LAST];
    assign ovf_raw = (a_q[LAST][WIDTH-1] == be_q[LAST][WIDTH-1]) &&
                     (raw[WIDTH-1] != a_q[LAST][WIDTH-1]);

`ifdef CLA_SAT_EN
    // Overflow direction follows the sign of A: A>=0 can only overflow upward.
    always_comb begin
        res = raw;
        if (sat_q[LAST] && ovf_raw) begin
            res = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res = raw;
`endif

    assign o_valid = v_q[LAST];
    assign o_sum   = res;
    assign o_cout  = v_q[LAST] && c_q[LAST];
    assign o_ovf   = v_q[LAST] && ovf_raw;
    assign o_zero  = v_q[LAST] && (res == '0);

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - self-checking scoreboard bench for cla_addsub_pipe
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        o_ready;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        sub_i = 1'b0;
    logic        sat_i = 1'b0;
    logic        o_valid;
    logic        rdy_i = 1'b1;
    logic [31:0] o_sum;
    logic        o_cout;
    logic        o_ovf;
    logic        o_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        t;
        logic [34:0] e;   // {zero, ovf, cout, sum}
    } op_t;

    op_t         ops[$];
    logic [34:0] exp_q[$];

    cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid_i),
        .o_ready (o_ready),
        .i_a     (a_i),
        .i_b     (b_i),
        .i_sub   (sub_i),
        .i_sat   (sat_i),
        .o_valid (o_valid),
        .i_ready (rdy_i),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    // Reference: 33-bit arithmetic on the two's-complement operands.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic t);
        logic [31:0] be;
        logic [32:0] full;
        logic [31:0] res;
        logic        ovf;
        be   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {32'd0, s};
        ovf  = (a[31] == be[31]) && (full[31] != a[31]);
        res  = full[31:0];
`ifdef CLA_SAT_EN
        if (t && ovf) res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (t) res = full[31:0];
`endif
        return {(res == 32'd0), ovf, full[32], res};
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic t, input logic [34:0] e);
        op_t o;
        o.a = a; o.b = b; o.s = s; o.t = t; o.e = e;
        return o;
    endfunction

    // Streams everything in ops[], scoreboarding each output handshake.
    task automatic run_ops(input int stall_start, input int stall_len, input bit rnd);
        int          idx = 0;
        int          cyc = 0;
        logic        held = 1'b0;
        logic [34:0] snap = '0;
        logic [34:0] got;
        logic [34:0] e;
        while ((idx < ops.size() || exp_q.size() != 0) && cyc < 300) begin
            @(negedge clk);
            if (rnd) rdy_i = ($urandom_range(0, 3) != 0);
            else     rdy_i = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (idx < ops.size()) begin
                valid_i = 1'b1;
                a_i = ops[idx].a; b_i = ops[idx].b; sub_i = ops[idx].s; sat_i = ops[idx].t;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            got = {o_zero, o_ovf, o_cout, o_sum};
            if (held) begin
                total++;
                if (o_valid !== 1'b1 || got !== snap) begin
                    bad++;
                    $display("FAIL hold_stable: got v=%b %h required v=1 %h", o_valid, got, snap);
                end
            end
            if (o_valid && !rdy_i) begin
                total++;
                if (o_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_in_stall: got %b required 0", o_ready);
                end
            end
            if (o_valid && rdy_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_result: got %h required none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL result: got %h required %h", got, e);
                    end
                end
            end
            if (valid_i && o_ready) begin
                exp_q.push_back(ops[idx].e);
                idx++;
            end
            held = o_valid && !rdy_i;
            snap = got;
            cyc++;
        end
        @(negedge clk);
        valid_i = 1'b0;
        rdy_i   = 1'b1;
        total++;
        if (idx != ops.size() || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got sent=%0d pending=%0d required sent=%0d pending=0",
                     idx, exp_q.size(), ops.size());
        end
        ops.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({o_valid, o_zero, o_ovf, o_cout, o_sum} !== 36'd0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got v=%b z=%b o=%b c=%b sum=%h rdy=%b required zeros rdy=1",
                     o_valid, o_zero, o_ovf, o_cout, o_sum, o_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        @(negedge clk);
        rdy_i = 1'b1; valid_i = 1'b1; a_i = 32'd5; b_i = 32'd3; sub_i = 1'b0; sat_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got o_valid=%b required 0", o_valid);
        end
        @(negedge clk);
        total++;
        if (o_valid !== 1'b1 || {o_zero, o_ovf, o_cout, o_sum} !== {3'b000, 32'h8}) begin
            bad++;
            $display("FAIL latency_result: got v=%b %h required v=1 %h",
                     o_valid, {o_zero, o_ovf, o_cout, o_sum}, {3'b000, 32'h8});
        end
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_single: got o_valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_carry;
        ops.push_back(mk(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, {3'b000, 32'h0001_0000}));
        ops.push_back(mk(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {3'b101, 32'h0}));
        ops.push_back(mk(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, {3'b000, 32'h0100_0000}));
        run_ops(1000, 0, 1'b0);
    endtask

    task automatic test_subtract;
        ops.push_back(mk(32'd5, 32'd5, 1'b1, 1'b0, {3'b101, 32'h0}));
        ops.push_back(mk(32'd3, 32'd5, 1'b1, 1'b0, {3'b000, 32'hFFFF_FFFE}));
        ops.push_back(mk(32'h0001_0000, 32'h1, 1'b1, 1'b0, {3'b001, 32'h0000_FFFF}));
        run_ops(1000, 0, 1'b0);
    endtask

    task automatic test_overflow;
`ifdef CLA_SAT_EN
        ops.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, {3'b010, 32'h7FFF_FFFF}));
        ops.push_back(mk(32'h8000_0000, 32'h1, 1'b1, 1'b1, {3'b011, 32'h8000_0000}));
`else
        ops.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, {3'b010, 32'h8000_0000}));
        ops.push_back(mk(32'h8000_0000, 32'h1, 1'b1, 1'b1, {3'b011, 32'h7FFF_FFFF}));
`endif
        ops.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {3'b010, 32'h8000_0000}));
        run_ops(1000, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] s;
        for (int i = 0; i < 8; i++) begin
            s = 32'(2 * i);
            ops.push_back(mk(32'(i), 32'(i), 1'b0, 1'b0, {(s == 32'd0), 2'b00, s}));
        end
        run_ops(4, 3, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        rt;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 4 == 0) ra = {ra[31], 31'h7FFF_FFF0 ^ ra[30:0]};
            rs = 1'($urandom_range(0, 1)); rt = 1'($urandom_range(0, 1));
            ops.push_back(mk(ra, rb, rs, rt, model(ra, rb, rs, rt)));
        end
        run_ops(0, 0, 1'b1);
    endtask

    task automatic test_reset_midflight;
        logic seen = 1'b0;
        @(negedge clk);
        rdy_i = 1'b0; valid_i = 1'b1; a_i = 32'd1; b_i = 32'd1; sub_i = 1'b0; sat_i = 1'b0;
        @(negedge clk);
        a_i = 32'd2; b_i = 32'd2;
        @(negedge clk);
        valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got o_valid=%b required 0", o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rdy_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_flush: got stale result=%b required 0", seen);
        end
        ops.push_back(mk(32'd3, 32'd4, 1'b0, 1'b0, {3'b000, 32'd7}));
        run_ops(1000, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_carry();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
